// File: rtl/tlb_unit.sv
//------------------------------------------------------------------------------
// Module   : tlb_unit
// Purpose  : 16-entry fully associative MIPS32 joint TLB. Performs tlbwi/tlbwr
//            writes, combinational tlbr reads and tlbp probes for CP0, and runs
//            two registered (1-cycle) lookup ports: instruction fetch and data.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            inst_tlbwi/inst_tlbwr - write strobes (tlbwi has priority)
//            random_index          - target entry of tlbwr
//            cp0_to_tlb_*          - EntryHi / EntryLo0 / EntryLo1 / Index
//            tlb_to_cp0_*          - probe result and entry readback
//            i_req/i_vaddr         - fetch lookup request
//            i_rsp_valid/i_paddr/i_ex            - fetch lookup result
//            d_req/d_wr/d_vaddr    - data lookup request
//            d_rsp_valid/d_paddr/d_ex/d_cache    - data lookup result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tlb_unit #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_tlbwi,
    input  logic             inst_tlbwr,
    input  logic [IDX_W-1:0] random_index,
    input  logic [18:0]      cp0_to_tlb_vpn2,
    input  logic [7:0]       cp0_to_tlb_asid,
    input  logic [IDX_W-1:0] cp0_to_tlb_index,
    input  logic [19:0]      cp0_to_tlb_pfn0,
    input  logic [2:0]       cp0_to_tlb_c0,
    input  logic             cp0_to_tlb_d0,
    input  logic             cp0_to_tlb_v0,
    input  logic             cp0_to_tlb_g0,
    input  logic [19:0]      cp0_to_tlb_pfn1,
    input  logic [2:0]       cp0_to_tlb_c1,
    input  logic             cp0_to_tlb_d1,
    input  logic             cp0_to_tlb_v1,
    input  logic             cp0_to_tlb_g1,
    output logic             tlb_to_cp0_found,
    output logic [IDX_W-1:0] tlb_to_cp0_index,
    output logic [18:0]      tlb_to_cp0_vpn2,
    output logic [7:0]       tlb_to_cp0_asid,
    output logic [19:0]      tlb_to_cp0_pfn0,
    output logic [2:0]       tlb_to_cp0_c0,
    output logic             tlb_to_cp0_d0,
    output logic             tlb_to_cp0_v0,
    output logic             tlb_to_cp0_g0,
    output logic [19:0]      tlb_to_cp0_pfn1,
    output logic [2:0]       tlb_to_cp0_c1,
    output logic             tlb_to_cp0_d1,
    output logic             tlb_to_cp0_v1,
    output logic             tlb_to_cp0_g1,
    input  logic             i_req,
    input  logic [31:0]      i_vaddr,
    output logic             i_rsp_valid,
    output logic [31:0]      i_paddr,
    output logic [1:0]       i_ex,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [31:0]      d_vaddr,
    output logic             d_rsp_valid,
    output logic [31:0]      d_paddr,
    output logic [1:0]       d_ex,
    output logic [2:0]       d_cache
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic [1:0]  ex;
    } lookup_t;

    localparam logic [1:0] EX_NONE    = 2'd0;
    localparam logic [1:0] EX_REFILL  = 2'd1;
    localparam logic [1:0] EX_INVALID = 2'd2;
    localparam logic [1:0] EX_MOD     = 2'd3;

    tlb_entry_t tlb_q [TLBNUM];
    tlb_entry_t tlb_d [TLBNUM];

    logic [TLBNUM-1:0] p_match;
    logic [TLBNUM-1:0] i_match;
    logic [TLBNUM-1:0] d_match;
    logic [IDX_W:0]    p_hit;
    logic [IDX_W:0]    i_hit;
    logic [IDX_W:0]    d_hit;

    logic        i_rsp_valid_q, i_rsp_valid_d;
    logic [31:0] i_paddr_q, i_paddr_d;
    logic [1:0]  i_ex_q, i_ex_d;
    logic        d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0] d_paddr_q, d_paddr_d;
    logic [1:0]  d_ex_q, d_ex_d;
    logic [2:0]  d_cache_q, d_cache_d;

    // Lowest matching index wins; result is {hit, index}, index 0 on miss.
    function automatic logic [IDX_W:0] pri_enc(input logic [TLBNUM-1:0] m);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = TLBNUM - 1; k >= 0; k--) begin
            if (m[k]) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

    function automatic lookup_t lookup(input logic [31:0] va, input logic hit,
                                       input tlb_entry_t e, input logic store);
        lookup_t     r;
        logic [19:0] pfn;
        logic        v;
        logic        d;
        r   = '0;
        pfn = va[12] ? e.pfn1 : e.pfn0;
        v   = va[12] ? e.v1   : e.v0;
        d   = va[12] ? e.d1   : e.d0;
        if (va[31:30] == 2'b10) begin
            r.paddr = {3'b000, va[28:0]};
        end else if (!hit) begin
            r.ex = EX_REFILL;
        end else if (!v) begin
            r.ex = EX_INVALID;
        end else if (store && !d) begin
            r.ex = EX_MOD;
        end else begin
            r.paddr = {pfn, va[11:0]};
        end
        return r;
    endfunction

    // A global entry ignores ASID; matching is done on the stored (pre-write)
    // contents, so a lookup in the write cycle sees the old entry.
    for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
        assign p_match[gi] = (tlb_q[gi].vpn2 == cp0_to_tlb_vpn2) &&
                             (tlb_q[gi].g || (tlb_q[gi].asid == cp0_to_tlb_asid));
        assign i_match[gi] = (tlb_q[gi].vpn2 == i_vaddr[31:13]) &&
                             (tlb_q[gi].g || (tlb_q[gi].asid == cp0_to_tlb_asid));
        assign d_match[gi] = (tlb_q[gi].vpn2 == d_vaddr[31:13]) &&
                             (tlb_q[gi].g || (tlb_q[gi].asid == cp0_to_tlb_asid));
    end

    assign p_hit = pri_enc(p_match);
    assign i_hit = pri_enc(i_match);
    assign d_hit = pri_enc(d_match);

    // Entry write: tlbwi takes priority over tlbwr.
    always_comb begin
        logic [IDX_W-1:0] widx;
        tlb_d = tlb_q;
        widx  = inst_tlbwi ? cp0_to_tlb_index : random_index;
        if (inst_tlbwi || inst_tlbwr) begin
            tlb_d[widx].vpn2 = cp0_to_tlb_vpn2;
            tlb_d[widx].asid = cp0_to_tlb_asid;
            tlb_d[widx].g    = cp0_to_tlb_g0 & cp0_to_tlb_g1;
            tlb_d[widx].pfn0 = cp0_to_tlb_pfn0;
            tlb_d[widx].c0   = cp0_to_tlb_c0;
            tlb_d[widx].d0   = cp0_to_tlb_d0;
            tlb_d[widx].v0   = cp0_to_tlb_v0;
            tlb_d[widx].pfn1 = cp0_to_tlb_pfn1;
            tlb_d[widx].c1   = cp0_to_tlb_c1;
            tlb_d[widx].d1   = cp0_to_tlb_d1;
            tlb_d[widx].v1   = cp0_to_tlb_v1;
        end
    end

    // Lookup ports: results hold their previous value when no request.
    always_comb begin
        lookup_t    ir;
        lookup_t    dr;
        tlb_entry_t de;
        de = tlb_q[d_hit[IDX_W-1:0]];
        ir = lookup(i_vaddr, i_hit[IDX_W], tlb_q[i_hit[IDX_W-1:0]], 1'b0);
        dr = lookup(d_vaddr, d_hit[IDX_W], de, d_wr);

        i_rsp_valid_d = i_req;
        i_paddr_d     = i_paddr_q;
        i_ex_d        = i_ex_q;
        d_rsp_valid_d = d_req;
        d_paddr_d     = d_paddr_q;
        d_ex_d        = d_ex_q;
        d_cache_d     = d_cache_q;

        if (i_req) begin
            i_paddr_d = ir.paddr;
            i_ex_d    = ir.ex;
        end
        if (d_req) begin
            d_paddr_d = dr.paddr;
            d_ex_d    = dr.ex;
            if (d_vaddr[31:30] == 2'b10) begin
                d_cache_d = d_vaddr[29] ? 3'd2 : 3'd3;
            end else if (dr.ex != EX_NONE) begin
                d_cache_d = 3'd0;
            end else begin
                d_cache_d = d_vaddr[12] ? de.c1 : de.c0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TLBNUM; k++) tlb_q[k] <= '0;
            i_rsp_valid_q <= 1'b0;
            i_paddr_q     <= '0;
            i_ex_q        <= '0;
            d_rsp_valid_q <= 1'b0;
            d_paddr_q     <= '0;
            d_ex_q        <= '0;
            d_cache_q     <= '0;
        end else begin
            tlb_q         <= tlb_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_paddr_q     <= i_paddr_d;
            i_ex_q        <= i_ex_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_paddr_q     <= d_paddr_d;
            d_ex_q        <= d_ex_d;
            d_cache_q     <= d_cache_d;
        end
    end

    assign i_rsp_valid = i_rsp_valid_q;
    assign i_paddr     = i_paddr_q;
    assign i_ex        = i_ex_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign d_paddr     = d_paddr_q;
    assign d_ex        = d_ex_q;
    assign d_cache     = d_cache_q;

    assign tlb_to_cp0_found = p_hit[IDX_W];
    assign tlb_to_cp0_index = p_hit[IDX_W-1:0];

    // G is stored once, so readback reports it on both halves.
    assign tlb_to_cp0_vpn2 = tlb_q[cp0_to_tlb_index].vpn2;
    assign tlb_to_cp0_asid = tlb_q[cp0_to_tlb_index].asid;
    assign tlb_to_cp0_pfn0 = tlb_q[cp0_to_tlb_index].pfn0;
    assign tlb_to_cp0_c0   = tlb_q[cp0_to_tlb_index].c0;
    assign tlb_to_cp0_d0   = tlb_q[cp0_to_tlb_index].d0;
    assign tlb_to_cp0_v0   = tlb_q[cp0_to_tlb_index].v0;
    assign tlb_to_cp0_g0   = tlb_q[cp0_to_tlb_index].g;
    assign tlb_to_cp0_pfn1 = tlb_q[cp0_to_tlb_index].pfn1;
    assign tlb_to_cp0_c1   = tlb_q[cp0_to_tlb_index].c1;
    assign tlb_to_cp0_d1   = tlb_q[cp0_to_tlb_index].d1;
    assign tlb_to_cp0_v1   = tlb_q[cp0_to_tlb_index].v1;
    assign tlb_to_cp0_g1   = tlb_q[cp0_to_tlb_index].g;

endmodule

`default_nettype wire

// File: tb/tb_tlb_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_tlb_unit
// Purpose  : Self-checking bench for tlb_unit. Lookup expectations are queued
//            when a request is driven and compared by a monitor whenever a
//            response is valid; CP0 probe/read results are compared directly.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tlb_unit;

    typedef struct {
        logic [31:0] pa;
        logic [1:0]  ex;
        logic [2:0]  c;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_tlbwi, inst_tlbwr;
    logic [3:0]  random_index;
    logic [18:0] cp0_to_tlb_vpn2;
    logic [7:0]  cp0_to_tlb_asid;
    logic [3:0]  cp0_to_tlb_index;
    logic [19:0] cp0_to_tlb_pfn0, cp0_to_tlb_pfn1;
    logic [2:0]  cp0_to_tlb_c0, cp0_to_tlb_c1;
    logic        cp0_to_tlb_d0, cp0_to_tlb_v0, cp0_to_tlb_g0;
    logic        cp0_to_tlb_d1, cp0_to_tlb_v1, cp0_to_tlb_g1;
    logic        tlb_to_cp0_found;
    logic [3:0]  tlb_to_cp0_index;
    logic [18:0] tlb_to_cp0_vpn2;
    logic [7:0]  tlb_to_cp0_asid;
    logic [19:0] tlb_to_cp0_pfn0, tlb_to_cp0_pfn1;
    logic [2:0]  tlb_to_cp0_c0, tlb_to_cp0_c1;
    logic        tlb_to_cp0_d0, tlb_to_cp0_v0, tlb_to_cp0_g0;
    logic        tlb_to_cp0_d1, tlb_to_cp0_v1, tlb_to_cp0_g1;
    logic        i_req;
    logic [31:0] i_vaddr;
    logic        i_rsp_valid;
    logic [31:0] i_paddr;
    logic [1:0]  i_ex;
    logic        d_req, d_wr;
    logic [31:0] d_vaddr;
    logic        d_rsp_valid;
    logic [31:0] d_paddr;
    logic [1:0]  d_ex;
    logic [2:0]  d_cache;

    int checks = 0;
    int errors = 0;
    exp_t iq[$];
    exp_t dq[$];

    tlb_unit #(.TLBNUM(16), .IDX_W(4)) dut (
        .clk(clk), .reset(reset),
        .inst_tlbwi(inst_tlbwi), .inst_tlbwr(inst_tlbwr), .random_index(random_index),
        .cp0_to_tlb_vpn2(cp0_to_tlb_vpn2), .cp0_to_tlb_asid(cp0_to_tlb_asid),
        .cp0_to_tlb_index(cp0_to_tlb_index),
        .cp0_to_tlb_pfn0(cp0_to_tlb_pfn0), .cp0_to_tlb_c0(cp0_to_tlb_c0),
        .cp0_to_tlb_d0(cp0_to_tlb_d0), .cp0_to_tlb_v0(cp0_to_tlb_v0), .cp0_to_tlb_g0(cp0_to_tlb_g0),
        .cp0_to_tlb_pfn1(cp0_to_tlb_pfn1), .cp0_to_tlb_c1(cp0_to_tlb_c1),
        .cp0_to_tlb_d1(cp0_to_tlb_d1), .cp0_to_tlb_v1(cp0_to_tlb_v1), .cp0_to_tlb_g1(cp0_to_tlb_g1),
        .tlb_to_cp0_found(tlb_to_cp0_found), .tlb_to_cp0_index(tlb_to_cp0_index),
        .tlb_to_cp0_vpn2(tlb_to_cp0_vpn2), .tlb_to_cp0_asid(tlb_to_cp0_asid),
        .tlb_to_cp0_pfn0(tlb_to_cp0_pfn0), .tlb_to_cp0_c0(tlb_to_cp0_c0),
        .tlb_to_cp0_d0(tlb_to_cp0_d0), .tlb_to_cp0_v0(tlb_to_cp0_v0), .tlb_to_cp0_g0(tlb_to_cp0_g0),
        .tlb_to_cp0_pfn1(tlb_to_cp0_pfn1), .tlb_to_cp0_c1(tlb_to_cp0_c1),
        .tlb_to_cp0_d1(tlb_to_cp0_d1), .tlb_to_cp0_v1(tlb_to_cp0_v1), .tlb_to_cp0_g1(tlb_to_cp0_g1),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_rsp_valid(i_rsp_valid),
        .i_paddr(i_paddr), .i_ex(i_ex),
        .d_req(d_req), .d_wr(d_wr), .d_vaddr(d_vaddr), .d_rsp_valid(d_rsp_valid),
        .d_paddr(d_paddr), .d_ex(d_ex), .d_cache(d_cache)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare each valid response against the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (i_rsp_valid) begin
            if (iq.size() == 0) check("i_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = iq.pop_front();
                check({e.name, "_i_paddr"}, i_paddr, e.pa);
                check({e.name, "_i_ex"}, {30'd0, i_ex}, {30'd0, e.ex});
            end
        end
        if (d_rsp_valid) begin
            if (dq.size() == 0) check("d_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = dq.pop_front();
                check({e.name, "_d_paddr"}, d_paddr, e.pa);
                check({e.name, "_d_ex"}, {30'd0, d_ex}, {30'd0, e.ex});
                check({e.name, "_d_cache"}, {29'd0, d_cache}, {29'd0, e.c});
            end
        end
    end

    task automatic set_fields(input logic [18:0] vpn2, input logic [7:0] asid,
                              input logic [19:0] pfn0, input logic [2:0] c0,
                              input logic d0, input logic v0, input logic g0,
                              input logic [19:0] pfn1, input logic [2:0] c1,
                              input logic d1, input logic v1, input logic g1);
        cp0_to_tlb_vpn2 = vpn2; cp0_to_tlb_asid = asid;
        cp0_to_tlb_pfn0 = pfn0; cp0_to_tlb_c0 = c0; cp0_to_tlb_d0 = d0;
        cp0_to_tlb_v0 = v0; cp0_to_tlb_g0 = g0;
        cp0_to_tlb_pfn1 = pfn1; cp0_to_tlb_c1 = c1; cp0_to_tlb_d1 = d1;
        cp0_to_tlb_v1 = v1; cp0_to_tlb_g1 = g1;
    endtask

    task automatic do_write(input logic wi, input logic wr,
                            input logic [3:0] idx, input logic [3:0] ridx);
        @(negedge clk);
        inst_tlbwi = wi; inst_tlbwr = wr;
        cp0_to_tlb_index = idx; random_index = ridx;
        @(negedge clk);
        inst_tlbwi = 1'b0; inst_tlbwr = 1'b0;
    endtask

    task automatic d_look(input string nm, input logic [31:0] va, input logic wr,
                          input logic [7:0] asid, input logic [31:0] pa,
                          input logic [1:0] ex, input logic [2:0] c);
        @(negedge clk);
        d_req = 1'b1; d_vaddr = va; d_wr = wr; cp0_to_tlb_asid = asid;
        dq.push_back('{pa, ex, c, nm});
        @(negedge clk);
        d_req = 1'b0; d_wr = 1'b0;
    endtask

    task automatic i_look(input string nm, input logic [31:0] va, input logic [7:0] asid,
                          input logic [31:0] pa, input logic [1:0] ex);
        @(negedge clk);
        i_req = 1'b1; i_vaddr = va; cp0_to_tlb_asid = asid;
        iq.push_back('{pa, ex, 3'd0, nm});
        @(negedge clk);
        i_req = 1'b0;
    endtask

    task automatic probe(input string nm, input logic [18:0] vpn2, input logic [7:0] asid,
                         input logic found, input logic [3:0] idx);
        @(negedge clk);
        cp0_to_tlb_vpn2 = vpn2; cp0_to_tlb_asid = asid;
        #1;
        check({nm, "_found"}, {31'd0, tlb_to_cp0_found}, {31'd0, found});
        check({nm, "_index"}, {28'd0, tlb_to_cp0_index}, {28'd0, idx});
    endtask

    initial begin
        reset = 1'b1; inst_tlbwi = 1'b0; inst_tlbwr = 1'b0;
        random_index = '0; cp0_to_tlb_index = '0;
        set_fields(19'd0, 8'd0, 20'd0, 3'd0, 1'b0, 1'b0, 1'b0, 20'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_wr = 1'b0; d_vaddr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_i_valid", {31'd0, i_rsp_valid}, 32'd0);
        check("rst_d_valid", {31'd0, d_rsp_valid}, 32'd0);
        check("rst_d_paddr", d_paddr, 32'd0);
        check("rst_d_ex", {30'd0, d_ex}, 32'd0);
        check("rst_d_cache", {29'd0, d_cache}, 32'd0);

        // Refill after reset
        d_look("refill_rst", 32'h0040_2000, 1'b0, 8'h00, 32'd0, 2'd1, 3'd0);
        probe("probe_rst", 19'h00201, 8'h00, 1'b0, 4'd0);

        // tlbwi then lookups
        set_fields(19'h00201, 8'h05, 20'h12345, 3'd3, 1'b1, 1'b1, 1'b0,
                   20'h0ABCD, 3'd2, 1'b0, 1'b0, 1'b0);
        do_write(1'b1, 1'b0, 4'd3, 4'd0);
        #1;
        check("rd3_vpn2", {13'd0, tlb_to_cp0_vpn2}, 32'h00201);
        check("rd3_pfn1", {12'd0, tlb_to_cp0_pfn1}, 32'h0ABCD);
        check("rd3_g0", {31'd0, tlb_to_cp0_g0}, 32'd0);
        d_look("even_hit", 32'h0040_2ABC, 1'b0, 8'h05, 32'h1234_5ABC, 2'd0, 3'd3);
        d_look("odd_inv", 32'h0040_3ABC, 1'b0, 8'h05, 32'd0, 2'd2, 3'd0);
        d_look("asid_miss", 32'h0040_2ABC, 1'b0, 8'h06, 32'd0, 2'd1, 3'd0);
        i_look("i_even_hit", 32'h0040_2ABC, 8'h05, 32'h1234_5ABC, 2'd0);
        probe("probe_hit3", 19'h00201, 8'h05, 1'b1, 4'd3);

        // Modified, then lowest-index priority
        set_fields(19'h00300, 8'h05, 20'h00777, 3'd2, 1'b0, 1'b1, 1'b0,
                   20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        do_write(1'b1, 1'b0, 4'd5, 4'd0);
        d_look("mod_store", 32'h0060_0123, 1'b1, 8'h05, 32'd0, 2'd3, 3'd0);
        d_look("mod_load", 32'h0060_0123, 1'b0, 8'h05, 32'h0077_7123, 2'd0, 3'd2);
        set_fields(19'h00300, 8'h05, 20'h00111, 3'd3, 1'b1, 1'b1, 1'b0,
                   20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        do_write(1'b1, 1'b0, 4'd1, 4'd0);
        d_look("prio_low", 32'h0060_0123, 1'b1, 8'h05, 32'h0011_1123, 2'd0, 3'd3);
        probe("probe_prio", 19'h00300, 8'h05, 1'b1, 4'd1);

        // Global and tlbwr
        set_fields(19'h10000, 8'h11, 20'h00AAA, 3'd3, 1'b1, 1'b1, 1'b1,
                   20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        do_write(1'b0, 1'b1, 4'd0, 4'd9);
        cp0_to_tlb_index = 4'd9;
        #1;
        check("wr9_vpn2", {13'd0, tlb_to_cp0_vpn2}, 32'h10000);
        check("wr9_g0", {31'd0, tlb_to_cp0_g0}, 32'd0);
        check("wr9_g1", {31'd0, tlb_to_cp0_g1}, 32'd0);
        d_look("nonglobal_miss", 32'h2000_0004, 1'b0, 8'h77, 32'd0, 2'd1, 3'd0);
        set_fields(19'h10000, 8'h11, 20'h00AAA, 3'd3, 1'b1, 1'b1, 1'b1,
                   20'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        do_write(1'b0, 1'b1, 4'd0, 4'd9);
        cp0_to_tlb_index = 4'd9;
        #1;
        check("wr9g_g0", {31'd0, tlb_to_cp0_g0}, 32'd1);
        check("wr9g_g1", {31'd0, tlb_to_cp0_g1}, 32'd1);
        d_look("global_hit", 32'h2000_0004, 1'b0, 8'h77, 32'h00AA_A004, 2'd0, 3'd3);
        i_look("i_global_hit", 32'h2000_0004, 8'h33, 32'h00AA_A004, 2'd0);

        // Both strobes: tlbwi wins
        set_fields(19'h10100, 8'h01, 20'h00BBB, 3'd3, 1'b1, 1'b1, 1'b0,
                   20'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        do_write(1'b1, 1'b1, 4'd10, 4'd11);
        cp0_to_tlb_index = 4'd11;
        #1;
        check("both_rd11_vpn2", {13'd0, tlb_to_cp0_vpn2}, 32'd0);
        cp0_to_tlb_index = 4'd10;
        #1;
        check("both_rd10_vpn2", {13'd0, tlb_to_cp0_vpn2}, 32'h10100);

        // Unmapped segments
        i_look("kseg1_i", 32'hBFC0_0380, 8'h00, 32'h1FC0_0380, 2'd0);
        d_look("kseg0_d", 32'h8000_0010, 1'b0, 8'h00, 32'h0000_0010, 2'd0, 3'd3);
        d_look("kseg1_d", 32'hA000_0020, 1'b1, 8'h00, 32'h0000_0020, 2'd0, 3'd2);

        // Write/lookup collision, back-to-back requests
        @(negedge clk);
        set_fields(19'h00201, 8'h05, 20'h54321, 3'd3, 1'b1, 1'b1, 1'b0,
                   20'h0ABCD, 3'd2, 1'b0, 1'b0, 1'b0);
        inst_tlbwi = 1'b1; cp0_to_tlb_index = 4'd3;
        d_req = 1'b1; d_wr = 1'b0; d_vaddr = 32'h0040_2ABC;
        dq.push_back('{32'h1234_5ABC, 2'd0, 3'd3, "coll_old"});
        @(negedge clk);
        inst_tlbwi = 1'b0;
        dq.push_back('{32'h5432_1ABC, 2'd0, 3'd3, "coll_new"});
        @(negedge clk);
        d_req = 1'b0;

        // Reset asserted with a request pending drops the response
        @(negedge clk);
        reset = 1'b1; d_req = 1'b1; d_vaddr = 32'h8000_0040;
        @(posedge clk);
        #2;
        check("rst_drop_valid", {31'd0, d_rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0;
        @(posedge clk);
        #2;
        check("rst_drop_valid2", {31'd0, d_rsp_valid}, 32'd0);
        probe("probe_after_rst", 19'h00201, 8'h05, 1'b0, 4'd0);

        repeat (3) @(negedge clk);
        check("i_queue_drained", iq.size(), 32'd0);
        check("d_queue_drained", dq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
